// File: rtl/lzd_norm_pipe.sv
// Two-stage leading-zero / leading-sign counter with left-normalising shifter.
// Optional all-zero/all-sign result counter is enabled by defining LZD_ALLZ_CNT_EN.
module lzd_norm_pipe #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef LZD_ALLZ_CNT_EN
  input  logic             clr,
  output logic [15:0]      allz_cnt,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_m,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_num,
  output logic             out_all,
  output logic [WIDTH-1:0] out_norm
);

  localparam int NG = WIDTH / 4;

  // Handshake: a beat moves across a port at a rising edge where valid && ready;
  // a producer holds valid and data stable until then, and ready may depend
  // combinationally on the downstream ready (no skid buffer).

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_m_q;
  logic [CW-1:0]    s1_num_q;
  logic             s1_all_q;
  logic             out_valid_q;
  logic [CW-1:0]    out_num_q;
  logic             out_all_q;
  logic [WIDTH-1:0] out_norm_q;

  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] scan;
  logic [NG-1:0]    grp_nz;
  logic [NG-1:0][1:0] grp_lz;
  logic [CW-1:0]    num_d;
  logic             all_d;
  logic             hit;

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // Sign mode counts leading zeros of the neighbour-xor vector: bit i+1 set
  // wherever m[i+1] != m[i]; bit 0 is forced clear so all-equal gives zero.
  always_comb begin
    scan = in_m;
    if (in_mode) scan = {in_m[WIDTH-1:1] ^ in_m[WIDTH-2:0], 1'b0};
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    assign grp_nz[g] = |scan[4*g +: 4];
    assign grp_lz[g] = scan[4*g+3] ? 2'd0 :
                       scan[4*g+2] ? 2'd1 :
                       scan[4*g+1] ? 2'd2 : 2'd3;
  end

  always_comb begin
    num_d = '0;
    hit   = 1'b0;
    for (int g = NG - 1; g >= 0; g--) begin
      if (!hit && grp_nz[g]) begin
        hit   = 1'b1;
        num_d = CW'(4 * (NG - 1 - g)) + CW'(grp_lz[g]);
      end
    end
    all_d = !hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_m_q     <= '0;
      s1_num_q   <= '0;
      s1_all_q   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_m_q   <= in_m;
        s1_num_q <= num_d;
        s1_all_q <= all_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_num_q   <= '0;
      out_all_q   <= 1'b0;
      out_norm_q  <= '0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_num_q  <= s1_num_q;
        out_all_q  <= s1_all_q;
        out_norm_q <= s1_m_q << s1_num_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_num   = out_num_q;
  assign out_all   = out_all_q;
  assign out_norm  = out_norm_q;

`ifdef LZD_ALLZ_CNT_EN
  logic [15:0] allz_cnt_q;
  logic [15:0] allz_cnt_d;

  always_comb begin
    allz_cnt_d = allz_cnt_q;
    if (clr)
      allz_cnt_d = '0;
    else if (out_valid_q && out_ready && out_all_q && allz_cnt_q != 16'hFFFF)
      allz_cnt_d = allz_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) allz_cnt_q <= '0;
    else        allz_cnt_q <= allz_cnt_d;
  end

  assign allz_cnt = allz_cnt_q;
`endif

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Scoreboard bench for lzd_norm_pipe: driver tasks push expected results,
// an independent monitor pops and compares on every output transfer.
module tb_lzd_norm_pipe;

  localparam int W  = 32;
  localparam int CW = $clog2(W);
  localparam int EW = CW + 1 + W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_m = '0;
  logic          in_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] out_num;
  logic          out_all;
  logic [W-1:0]  out_norm;
`ifdef LZD_ALLZ_CNT_EN
  logic          clr = 1'b0;
  logic [15:0]   allz_cnt;
`endif

  logic [EW-1:0] exp_q[$];
  logic          rdy_rand = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  always begin
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  lzd_norm_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef LZD_ALLZ_CNT_EN
    .clr       (clr),
    .allz_cnt  (allz_cnt),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_m      (in_m),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_num   (out_num),
    .out_all   (out_all),
    .out_norm  (out_norm)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [W-1:0] m, input logic mode);
    int n;
    logic allz;
    n = 0;
    allz = 1'b0;
    if (!mode) begin
      if (m == '0) allz = 1'b1;
      else while (m[W-1-n] == 1'b0) n++;
    end else begin
      if (m == '0 || m == '1) allz = 1'b1;
      else while (m[W-2-n] == m[W-1]) n++;
    end
    return {CW'(n), allz, m << n};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] m, input logic mode, input logic [EW-1:0] exp);
    int cyc;
    logic acc;
    in_valid = 1'b1;
    in_m     = m;
    in_mode  = mode;
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("accept_timeout", acc, 1);
    if (acc) exp_q.push_back(exp);
    in_valid = 1'b0;
    in_m     = W'($urandom);
    in_mode  = 1'($urandom);
  endtask

  task automatic send_m(input logic [W-1:0] m, input logic mode);
    send(m, mode, model(m, mode));
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    v = W'($urandom) >> $urandom_range(0, W);
    if ($urandom_range(0, 1) == 1) v = ~v;
    if ($urandom_range(0, 15) == 0) v = '0;
    if ($urandom_range(0, 15) == 0) v = '1;
    return v;
  endfunction

  task automatic drain();
    int cyc;
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic          stall_seen;
    logic [EW-1:0] held;
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    stall_seen = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      act = {out_num, out_all, out_norm};
      if (!rst_n) begin
        stall_seen = 1'b0;
      end else begin
        if (stall_seen) begin
          check("stall_valid_hold", out_valid, 1);
          check("stall_data_hold", act, held);
        end
        if (out_valid && out_ready) begin
          check("output_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_num", out_num, e[EW-1:W+1]);
            check("out_all", out_all, e[W]);
            check("out_norm", out_norm, e[W-1:0]);
          end
        end
        stall_seen = out_valid && !out_ready;
        held = act;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_num", out_num, 0);
    check("rst_out_all", out_all, 0);
    check("rst_out_norm", out_norm, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

`ifdef LZD_ALLZ_CNT_EN
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("allz_cnt_clr", allz_cnt, 0);
    send(32'h0, 1'b0, {5'd0, 1'b1, 32'h0});
    send(32'h0, 1'b0, {5'd0, 1'b1, 32'h0});
    send(32'h0, 1'b0, {5'd0, 1'b1, 32'h0});
    send(32'h10, 1'b0, {5'd27, 1'b0, 32'h8000_0000});
    drain();
    check("allz_cnt_three", allz_cnt, 3);
    out_ready = 1'b0;
    send(32'h0, 1'b0, {5'd0, 1'b1, 32'h0});
    @(posedge clk);
    #1;
    check("allz_pending_valid", out_valid, 1);
    clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("allz_cnt_clr_priority", allz_cnt, 0);
    drain();
`endif

    // directed vectors
    send(32'h0000_1234, 1'b0, {5'd19, 1'b0, 32'h91A0_0000});
    send(32'h0000_0000, 1'b0, {5'd0,  1'b1, 32'h0000_0000});
    send(32'hFFFF_FFFF, 1'b1, {5'd0,  1'b1, 32'hFFFF_FFFF});
    send(32'hFFFF_F800, 1'b1, {5'd20, 1'b0, 32'h8000_0000});
    send(32'h0000_00FF, 1'b1, {5'd23, 1'b0, 32'h7F80_0000});
    send(32'h8000_0000, 1'b0, {5'd0,  1'b0, 32'h8000_0000});
    send(32'h0000_0001, 1'b0, {5'd31, 1'b0, 32'h8000_0000});
    send(32'h0000_0000, 1'b1, {5'd0,  1'b1, 32'h0000_0000});
    send(32'h4000_0000, 1'b1, {5'd0,  1'b0, 32'h4000_0000});
    send(32'h0000_0001, 1'b1, {5'd30, 1'b0, 32'h4000_0000});
    send(32'hFFFF_FFFE, 1'b1, {5'd30, 1'b0, 32'h8000_0000});
    drain();

    // backpressure: four back-to-back operands, consumer stalled
    out_ready = 1'b0;
    fork
      begin
        send_m(32'h0001_0000, 1'b0);
        send_m(32'hFFF0_0000, 1'b1);
        send_m(32'h0000_0003, 1'b0);
        send_m(32'h0F00_0000, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready_low", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // randomized traffic with random backpressure and idle gaps
    rdy_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_m    = W'($urandom);
        in_mode = 1'($urandom);
        @(posedge clk);
        #1;
      end else begin
        send_m(rand_op(), 1'($urandom));
      end
    end
    drain();

    // reset with two operands in flight
    out_ready = 1'b0;
    send_m(32'h0000_0800, 1'b0);
    send_m(32'hFFFF_0000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_norm", out_norm, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("postrst_no_stale", out_valid, 0);
    end
    send_m(32'h0000_0040, 1'b0);
    check("latency_not_early", out_valid, 0);
    @(posedge clk);
    #1;
    check("latency_two", out_valid, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lzd_norm_pipe.md
Name: lzd_norm_pipe

Overview:
- Parametrised, pipelined leading-zero / leading-sign counter with an integrated left-normalising shifter for the MAC datapath.
- Sits between the accumulator and the rounding/pack stage. Returns the shift count, the all-zero/all-sign flag and the normalised mantissa in one transaction.
- Valid/ready handshake on both sides with full-throughput backpressure.

Parameters:
- WIDTH, 32, operand width; power of two, 8..64.
- CW, $clog2(WIDTH), count width; derived, not to be overridden.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operand this cycle
- in_m  in  WIDTH  operand
- in_mode  in  1  0 = count leading zeros; 1 = count redundant sign bits
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_num  out  CW  shift count
- out_all  out  1  operand carries no leading one (mode 0) / no sign change (mode 1)
- out_norm  out  WIDTH  operand shifted left by out_num, zero-filled

Behaviour:
- Reset is asynchronous on rst_n low. While low and on release: out_valid=0, out_num=0, out_all=0, out_norm=0, both stage-valid flags 0. in_ready is 1 once rst_n is high.
- Transfer on the input occurs when in_valid && in_ready at a rising edge. Transfer on the output occurs when out_valid && out_ready at a rising edge.
- Stage 1 (count): computes num and all combinationally from in_m/in_mode, using 4-bit group priority encoding. It registers m, num and all into s1.
- Stage 2 (shift): out_norm <= s1_m << s1_num. out_num and out_all are carried forward.
- Latency: an operand accepted at edge N gives out_valid=1 after edge N+1.
- Throughput: one operand per cycle while out_ready=1.
- Advance rules:
  - s2 loads when !out_valid || out_ready.
  - s1 loads when !s1_valid || s2 loads.
  - in_ready = !s1_valid || s2 loads (combinational from out_ready; no skid buffer).
- Stall: while out_valid && !out_ready, out_valid, out_num, out_all and out_norm hold stable and s1 holds. in_ready drops once s1 is occupied.
- Mode 0, count rule: num = number of consecutive 0s from bit WIDTH-1 down to the first 1.
- Mode 0, all-zero operand: out_all=1, out_num=0, out_norm=0.
- Mode 1, count rule: num = number of bits below the MSB, from bit WIDTH-2 downward, that equal bit WIDTH-1, stopping at the first mismatch. Range 0..WIDTH-2.
- Mode 1, all-0s or all-1s operand: out_all=1, out_num=0, out_norm=in_m unchanged.
- out_all=0 means out_norm[WIDTH-1] is 1 in mode 0. In mode 1 it means out_norm[WIDTH-1] != out_norm[WIDTH-2].
- in_mode is captured per transaction. Mixed modes back-to-back are legal.
- Data fields are ignored when the matching valid is 0. Registers are cleared only by reset.
- Reset mid-stream drops all in-flight operands; no output transfer occurs for them.

Optional Feature:
- Macro: LZD_ALLZ_CNT_EN.
- Defined: adds input clr (1 bit) and output allz_cnt (16 bits).
  - allz_cnt increments on each output transfer with out_all=1 and saturates at 16'hFFFF.
  - A synchronous clr=1 forces it to 0; clr has priority over increment.
  - Reset value is 0.
- Not defined: the ports and the counter are absent. Behaviour is otherwise identical.

Test Plan:
- Mode 0, WIDTH=32, in_m=32'h0000_1234, out_ready=1 -> two cycles later: out_num=19, out_all=0, out_norm=32'h91A0_0000.
- Mode 0 in_m=0, then mode 1 in_m=32'hFFFF_FFFF -> out_all=1, out_num=0 for both; out_norm 32'h0 then 32'hFFFF_FFFF.
- Mode 1, in_m=32'hFFFF_F800 -> out_num=20, out_norm=32'h8000_0000, out_all=0. Mode 1, in_m=32'h0000_00FF -> out_num=23, out_norm=32'h7F80_0000.
- Stream 4 operands back-to-back with out_ready held low for 3 cycles -> outputs frozen, in_ready=0 after s1 fills, no loss or duplication, order preserved.
- Assert rst_n low while 2 operands are in flight -> out_valid=0 immediately; after release, no stale result appears; the next operand completes with latency 2.
- LZD_ALLZ_CNT_EN defined: three all-zero operands plus one nonzero -> allz_cnt=3; pulse clr together with an all-zero output transfer -> allz_cnt=0.
